// File: rtl/mips_mem_responder.sv
// Single-outstanding word memory responder for a MIPS-style load/store initiator.
// Latency: resp_valid LATENCY cycles after the accepting cycle; one transaction per LATENCY+1 cycles.
// Backpressure: response (rdata/err) held stable in RESP until resp_ready; no new request accepted meanwhile.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   req_valid / req_ready      - request handshake (req_ready only in IDLE)
//   req_write, req_addr,
//   req_wdata, req_be          - request payload: store flag, byte address, store data, byte enables
//   resp_valid / resp_ready    - response handshake (resp_valid only in RESP)
//   resp_rdata, resp_err       - load data (0 for stores/errors), misaligned/out-of-range flag
module mips_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  enter_resp;
  logic                  e_write;
  logic [31:0]           e_addr;
  logic [31:0]           e_wdata;
  logic [3:0]            e_be;
  logic                  e_err;
  logic [ADDR_WIDTH-1:0] e_idx;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // The transaction completing this edge. With LATENCY == 1 it completes on
  // its own acceptance edge, so the live request inputs are used directly.
  always_comb begin
    enter_resp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                 ((state == WAIT) && (cnt == 4'd0));
    if (state == IDLE) begin
      e_write = req_write;
      e_addr  = req_addr;
      e_wdata = req_wdata;
      e_be    = req_be;
    end else begin
      e_write = r_write;
      e_addr  = r_addr;
      e_wdata = r_wdata;
      e_be    = r_be;
    end
    e_err = (e_addr[1:0] != 2'b00) || ((e_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    e_idx = e_addr[ADDR_WIDTH+1:2];
  end

  // Memory has no reset; a reset edge suppresses any commit on that edge.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && e_write && !e_err) begin
      for (int i = 0; i < 4; i++) begin
        if (e_be[i]) mem[e_idx][8*i +: 8] <= e_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Read happens before this edge's store lands; stores return 0 anyway.
      if (enter_resp) begin
        resp_err   <= e_err;
        resp_rdata <= (e_err || e_write) ? 32'd0 : mem[e_idx];
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: two instances (LATENCY 2 and 1), randomized and
// directed traffic, scoreboard queue per instance checked by a negedge monitor
// against a word-array reference model.
module tb_mips_mem_responder;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          acc;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  // Error if misaligned or beyond 1024 words (ADDR_WIDTH = 10 -> 4 KiB).
  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = 2 - g;
    txn_t q[$];
    logic [31:0] mdl [int];
    int acc_cnt = 0;

    mips_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );

    always @(negedge clk) begin
      txn_t        t;
      bit          ee;
      int          wd;
      logic [31:0] er;
      ee = 1'b0;
      wd = 0;
      if (q.size() > 0) begin
        t  = q[0];
        ee = is_err(t.a);
        wd = int'(t.a >> 2);
      end
      if (reset[g]) begin
        // A store already presented in RESP was committed; one still waiting is lost.
        if (q.size() > 0 && resp_valid[g] && t.w && !ee) mdl[wd] = merge(mdl[wd], t.d, t.be);
        q.delete();
      end else begin
        chk($sformatf("req_ready[%0d]", g), 32'(req_ready[g]), 32'(q.size() == 0));
        if (q.size() == 0) begin
          chk($sformatf("resp_valid_idle[%0d]", g), 32'(resp_valid[g]), 32'd0);
        end else begin
          chk($sformatf("resp_valid_timing[%0d]", g), 32'(resp_valid[g]),
              32'(cyc >= t.acc + LAT));
          if (resp_valid[g]) begin
            er = (ee || t.w) ? 32'h0 : mdl[wd];
            chk($sformatf("rdata[%0d] addr %h", g, t.a), resp_rdata[g], er);
            chk($sformatf("err[%0d] addr %h", g, t.a), 32'(resp_err[g]), 32'(ee));
            if (resp_ready[g]) begin
              if (t.w && !ee) mdl[wd] = merge(mdl[wd], t.d, t.be);
              void'(q.pop_front());
            end
          end
        end
        if (req_valid[g] && req_ready[g]) begin
          acc_cnt++;
          q.push_back('{w: req_write[g], a: req_addr[g], d: req_wdata[g], be: req_be[g], acc: cyc});
        end
      end
    end
  end

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int stall);
    int n;
    @(posedge clk); #1;
    req_valid[k]  = 1'b1;
    req_write[k]  = w;
    req_addr[k]   = a;
    req_wdata[k]  = d;
    req_be[k]     = be;
    resp_ready[k] = (stall == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) timeout("accept");
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid[k] && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) timeout("response");
    if (stall > 0) begin
      repeat (stall - 1) @(negedge clk);
      @(posedge clk); #1;
      resp_ready[k] = 1'b1;
    end
  endtask

  initial begin
    int          r, stall, k, b0;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0;
      req_wdata[i] = 32'd0; req_be[i] = 4'd0; resp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", 32'(req_ready[i]), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("reset_rdata", resp_rdata[i], 32'd0);
      chk("reset_err", 32'(resp_err[i]), 32'd0);
    end

    // Preload the first 32 words of both memories so every load has a known value.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 32; w++) txn(i, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

    // Store then load.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    // Partial store -> 0x11BB33DD.
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    // Misaligned load, out-of-range store aliasing word 0, then word 0 unchanged.
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    // Empty byte-enable store: no change, no error.
    txn(0, 1'b1, 32'h30, 32'h12345678, 4'h0, 0);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0);
    // Five cycles of response backpressure.
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset during WAIT drops a pending store.
    txn(0, 1'b1, 32'h40, 32'h0, 4'hF, 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h40;
    req_wdata[0] = 32'h55; req_be[0] = 4'hF; resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    @(negedge clk);
    chk("wait_reset_req_ready", 32'(req_ready[0]), 32'd1);
    chk("wait_reset_resp_valid", 32'(resp_valid[0]), 32'd0);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0);

    // LATENCY=1 with request held: accepted every other cycle.
    b0 = g_inst[1].acc_cnt;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h8; resp_ready[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("b2b_accepts", 32'(g_inst[1].acc_cnt - b0), 32'd4);

    // Randomized traffic on both instances.
    for (int n = 0; n < 160; n++) begin
      k = n % 2;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 31) * 4);
      if (r == 0)      a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a + (32'h1000 << $urandom_range(0, 19));
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      txn(k, 1'($urandom), a, $urandom, 4'($urandom), stall);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-index width (1024 x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i enables bits [8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  response presented.
REQ-012 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = (state == IDLE); resp_valid = (state == RESP).
REQ-016 SHALL accept a request on an edge where req_valid & req_ready, registering write, addr, wdata, be.
REQ-017 On acceptance, SHALL go to RESP if LATENCY == 1, else to WAIT with a counter loaded to LATENCY-2.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-019 SHALL assert resp_valid exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL flag an error when addr[1:0] != 0 or addr[31:ADDR_WIDTH+2] != 0.
REQ-021 SHALL use word index addr[ADDR_WIDTH+1:2] for non-error accesses.
REQ-022 SHALL commit a non-error store, enabled bytes only, on the WAIT/IDLE->RESP edge; req_be = 0 writes nothing and returns no error.
REQ-023 SHALL capture load data into resp_rdata on the same edge, reflecting all previously committed stores.
REQ-024 On error, SHALL leave memory unchanged, drive resp_rdata = 0 and resp_err = 1.
REQ-025 SHALL hold resp_rdata and resp_err stable while resp_valid & !resp_ready (backpressure of any length).
REQ-026 SHALL return to IDLE on an edge where resp_valid & resp_ready; req_ready rises the following cycle (no back-to-back).
REQ-027 SHALL ignore req_* inputs outside IDLE; a request held by the initiator is accepted only once in IDLE.
REQ-028 SHALL have sustained throughput of one transaction per LATENCY+1 cycles with resp_ready held at 1.
REQ-029 SHALL keep at most one transaction outstanding.

Reset
REQ-030 On reset, SHALL go to IDLE with counter = 0, resp_rdata = 0, resp_err = 0, so req_ready = 1 and resp_valid = 0 on the next cycle.
REQ-031 Reset in WAIT SHALL drop the pending transaction, and a pending store SHALL NOT be committed.
REQ-032 Reset in RESP SHALL discard the response; a store committed on RESP entry remains committed.
REQ-033 SHALL NOT initialise memory contents on reset.

Verification
REQ-034 Store then load, LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, be 0xF -> resp_valid 2 cycles after acceptance with err 0; read 0x10 -> rdata 0xDEADBEEF.
REQ-035 Partial store: write 0x11223344 to 0x20, then wdata 0xAABBCCDD with be 0b0101 -> read 0x20 returns 0x11BB33DD.
REQ-036 Errors: read 0x22 -> err 1, rdata 0; write 0x1000 (ADDR_WIDTH=10) -> err 1, and a read of 0x0 shows no change.
REQ-037 Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, rdata and err stable, req_ready 0; accepted on the 6th cycle, req_ready 1 the next cycle.
REQ-038 Reset mid-WAIT: store 0x55 to 0x40 (old value 0x0), assert reset in the WAIT cycle -> next cycle IDLE, req_ready 1, no resp_valid; read 0x40 returns 0x0.
REQ-039 Back-to-back with req_valid held and resp_ready = 1, LATENCY=1 -> acceptances every 2 cycles, each resp_valid one cycle after its acceptance.
